sd_dac: RTL and testbench

SD_DAC -- requirements
Module: sd_dac

---
 rtl/sd_dac.sv | 94 +++++++++
 tb/tb_sd_dac.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_dac.sv
// First-order sigma-delta DAC with a one-word holding register and a fixed update period.
// Optional LFSR dither on the accumulator carry-in is enabled by defining SD_DAC_DITHER_EN.
module sd_dac #(
  parameter int unsigned DAC_WIDTH   = 8,
  parameter int unsigned UPDATE_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DAC_WIDTH-1:0] digital_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 analog_out,
  output logic                 code_update,
  output logic                 underrun
);

  localparam int unsigned SUM_W = DAC_WIDTH + 1;

  logic [UPDATE_BITS-1:0] counter;
  logic [DAC_WIDTH-1:0]   hold_reg;
  logic                   hold_full;
  logic [DAC_WIDTH-1:0]   active_code;
  logic [DAC_WIDTH-1:0]   acc;
  logic [SUM_W-1:0]       sum;
  logic                   period_end;
  logic                   accept;
  logic                   carry_in;

  assign period_end   = &counter;
  assign sample_ready = ~hold_full;
  assign accept       = sample_valid & ~hold_full;

`ifdef SD_DAC_DITHER_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  // Fibonacci LFSR, taps 16,14,13,11
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr_fb};
  end

  assign carry_in = lfsr[0];
`else
  assign carry_in = 1'b0;
`endif

  assign sum = SUM_W'(acc) + SUM_W'(active_code) + SUM_W'(carry_in);

  // Update period counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) counter <= '0;
    else        counter <= counter + UPDATE_BITS'(1);
  end

  // Holding register and transfer to the active code at period end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg    <= '0;
      hold_full   <= 1'b0;
      active_code <= '0;
      code_update <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      code_update <= 1'b0;
      underrun    <= 1'b0;
      if (period_end && hold_full) begin
        active_code <= hold_reg;
        hold_full   <= 1'b0;
        code_update <= 1'b1;
      end else begin
        if (period_end) underrun <= 1'b1;
        if (accept) begin
          hold_reg  <= digital_in;
          hold_full <= 1'b1;
        end
      end
    end
  end

  // Modulator; accumulator is never cleared on a code change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      analog_out <= 1'b0;
    end else begin
      acc        <= sum[DAC_WIDTH-1:0];
      analog_out <= sum[DAC_WIDTH];
    end
  end

endmodule

// File: tb/tb_sd_dac.sv
// Scoreboard bench for sd_dac (DAC_WIDTH=8, UPDATE_BITS=10, dither off).
module tb_sd_dac;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] digital_in;
  logic       sample_valid;
  logic       sample_ready;
  logic       analog_out;
  logic       code_update;
  logic       underrun;

  int         total = 0;
  int         bad   = 0;
  int         cyc;
  int         n_acc = 0;
  int         last_acc_edge = -1;
  int         last_upd = -1;
  logic [7:0] exp_q[$];

  sd_dac #(.DAC_WIDTH(8), .UPDATE_BITS(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .digital_in   (digital_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .analog_out   (analog_out),
    .code_update  (code_update),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  // Edges since reset release; after edge N the value reads N
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Scoreboard push on every accepted word
  always @(posedge clk) begin
    if (rst_n === 1'b1 && sample_valid === 1'b1 && sample_ready === 1'b1) begin
      exp_q.push_back(digital_in);
      last_acc_edge = cyc + 1;
      n_acc++;
    end
  end

  task automatic write_word(input logic [7:0] code, input bit keep);
    int n0 = n_acc;
    int budget = 0;
    digital_in   = code;
    sample_valid = 1'b1;
    do begin @(negedge clk); budget++; end while (n_acc == n0 && budget < 2100);
    total++;
    if (n_acc == n0) begin
      bad++;
      $display("FAIL write_%02h: not accepted within %0d clocks", code, budget);
    end
    if (!keep) sample_valid = 1'b0;
  endtask

  // Waits for code_update, pops the expected code and counts ones over the next 256 bits
  task automatic check_update(input string name, input bit check_gap, output int reps);
    int budget = 0;
    int ones = 0;
    logic [7:0] exp;
    logic prev;
    reps = 0;
    do begin @(negedge clk); budget++; end while (code_update !== 1'b1 && budget < 2100);
    total++;
    if (code_update !== 1'b1) begin
      bad++;
      $display("FAIL %s_update: code_update=%b after %0d clocks, required 1", name, code_update, budget);
      return;
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s_pop: code_update with empty scoreboard, required a pending word", name);
      exp = 8'h00;
    end else begin
      exp = exp_q.pop_front();
    end
    total++;
    if (cyc % 1024 != 0) begin
      bad++;
      $display("FAIL %s_phase: update at clock %0d, required a multiple of 1024", name, cyc);
    end
    if (check_gap) begin
      total++;
      if (cyc - last_upd != 1024) begin
        bad++;
        $display("FAIL %s_gap: update spacing %0d, required 1024", name, cyc - last_upd);
      end
    end
    last_upd = cyc;
    prev = analog_out;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (analog_out === 1'b1) ones++;
      if (i > 0 && analog_out === prev) reps++;
      prev = analog_out;
    end
    total++;
    if (ones != int'(exp)) begin
      bad++;
      $display("FAIL %s_density: ones=%0d in 256 clocks, required %0d", name, ones, exp);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    digital_in   = 8'h00;
    exp_q.delete();
    last_upd = -1;
    repeat (3) @(negedge clk);
    total++;
    if (analog_out !== 1'b0 || code_update !== 1'b0 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: analog=%b update=%b underrun=%b, required 0 0 0",
               analog_out, code_update, underrun);
    end
    rst_n = 1'b1;
    total++;
    if (sample_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: sample_ready=%b, required 1", sample_ready);
    end
  endtask

  task automatic test_underrun(input string name);
    int n_und = 0;
    int n_upd = 0;
    int ones = 0;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (underrun === 1'b1) begin
        n_und++;
        total++;
        if (cyc % 1024 != 0) begin
          bad++;
          $display("FAIL %s_phase: underrun at clock %0d, required multiple of 1024", name, cyc);
        end
      end
      if (code_update === 1'b1) n_upd++;
      if (analog_out !== 1'b0) ones++;
    end
    total++;
    if (n_und != 2) begin
      bad++;
      $display("FAIL %s_count: underruns=%0d, required 2", name, n_und);
    end
    total++;
    if (n_upd != 0) begin
      bad++;
      $display("FAIL %s_noupdate: code_update pulses=%0d, required 0", name, n_upd);
    end
    total++;
    if (ones != 0) begin
      bad++;
      $display("FAIL %s_silent: nonzero analog bits=%0d, required 0", name, ones);
    end
  endtask

  task automatic test_half();
    int reps;
    write_word(8'h80, 1'b0);
    check_update("half", 1'b0, reps);
    total++;
    if (reps != 0) begin
      bad++;
      $display("FAIL half_alternate: repeated bits=%0d, required 0", reps);
    end
  endtask

  task automatic test_full_then_zero();
    int reps;
    write_word(8'hFF, 1'b0);
    check_update("full", 1'b1, reps);
    write_word(8'h00, 1'b0);
    check_update("zero", 1'b1, reps);
  endtask

  task automatic test_back_to_back();
    int reps;
    write_word(8'h40, 1'b1);
    total++;
    if (sample_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ready: sample_ready=%b while holding, required 0", sample_ready);
    end
    digital_in = 8'hC0;
    check_update("b2b_first", 1'b1, reps);
    sample_valid = 1'b0;
    total++;
    if (last_acc_edge % 1024 != 1) begin
      bad++;
      $display("FAIL b2b_accept: second word accepted at edge %0d, required 1 after a period end",
               last_acc_edge);
    end
    check_update("b2b_second", 1'b1, reps);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_lost: %0d words pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int reps;
    write_word(8'h80, 1'b0);
    check_update("pre_reset", 1'b1, reps);
    write_word(8'h33, 1'b0);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (analog_out !== 1'b0 || code_update !== 1'b0 || underrun !== 1'b0 || sample_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_async: analog=%b update=%b underrun=%b ready=%b, required 0 0 0 1",
               analog_out, code_update, underrun, sample_ready);
    end
    exp_q.delete();
    last_upd = -1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (sample_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_ready: sample_ready=%b after release, required 1", sample_ready);
    end
    test_underrun("midreset");
  endtask

  initial begin
    test_reset();
    test_underrun("idle");
    test_half();
    test_full_then_zero();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
